mem_arbiter_2port: RTL

- Two-requester round-robin arbiter and access sequencer for the 8 x 8-bit memory (D_IN, ADDR, R_ENABLE, W_ENABLE, D_OUT).
- Accepts single-word read/write requests from requesters A and B and grants one at a time.
- Drives the memory's enables for exactly one cycle per access, waits out the read latency and returns read data with a done pulse.
- Sits between the memory and its two client blocks. It is the only driver of the memory's data, address and enable inputs.

---
 rtl/mem_arbiter_2port.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_2port.sv
// -----------------------------------------------------------------------------
// mem_arbiter_2port
//
// Purpose:
//   Round-robin arbiter and access sequencer placed in front of a small
//   single-port memory (DATA_W x 2**ADDR_W). Two client blocks (A and B)
//   issue single-word read or write requests. One request is granted at a
//   time. The granted access is replayed onto the memory pins for exactly
//   one cycle. For a read, the block then waits out the memory read latency
//   and returns the data with a one-cycle done pulse.
//
// Ports:
//   CLK, RESET           clock; synchronous active-high reset
//   A_REQ / B_REQ        level request, sampled only while idle
//   A_WE  / B_WE         1 = write, 0 = read
//   A_ADDR / B_ADDR      target address
//   A_DIN / B_DIN        write data
//   A_GNT / B_GNT        one-cycle pulse: request latched
//   A_DONE / B_DONE      one-cycle pulse: access complete
//   A_DOUT / B_DOUT      last read data for that requester (held)
//   MEM_D_IN, MEM_ADDR   memory data/address (driven only while accessing)
//   MEM_R_ENABLE,
//   MEM_W_ENABLE         memory enables, one-cycle pulse per access
//   MEM_D_OUT            memory read data
//
// Timing (request sampled at edge 0):
//   cycle 1            GNT and the memory enable are high
//   cycle 2            DONE for a write
//   cycle 2+LAT        DONE for a read, DOUT already updated
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter_2port #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int MEM_READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,

  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DIN,
  output logic              A_GNT,
  output logic              A_DONE,
  output logic [DATA_W-1:0] A_DOUT,

  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DIN,
  output logic              B_GNT,
  output logic              B_DONE,
  output logic [DATA_W-1:0] B_DOUT,

  output logic [DATA_W-1:0] MEM_D_IN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_R_ENABLE,
  output logic              MEM_W_ENABLE,
  input  logic [DATA_W-1:0] MEM_D_OUT
);

  // Wait counter preload. The legal latency range 1..7 fits in 3 bits.
  localparam logic [2:0] READ_LAT_CNT = 3'(MEM_READ_LAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Requester inputs gathered into index-addressable form (0 = A, 1 = B).
  // ---------------------------------------------------------------------------
  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_vec [2];
  logic [DATA_W-1:0] din_vec  [2];
  logic [DATA_W-1:0] dout_vec [2];

  assign req_vec     = {B_REQ, A_REQ};
  assign we_vec      = {B_WE, A_WE};
  assign addr_vec[0] = A_ADDR;
  assign addr_vec[1] = B_ADDR;
  assign din_vec[0]  = A_DIN;
  assign din_vec[1]  = B_DIN;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  logic              pri_reg;      // requester favoured on a tie
  logic              op_idx_reg;   // owner of the current transaction
  logic              op_we_reg;    // current transaction is a write
  logic [2:0]        cnt_reg;      // read-latency countdown
  logic [1:0]        gnt_reg;
  logic [1:0]        done_reg;
  logic [DATA_W-1:0] mem_d_in_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_r_en_reg;
  logic              mem_w_en_reg;

  // ---------------------------------------------------------------------------
  // Winner selection. With a single request the requester that asserts wins,
  // so bit 1 of the request vector is the index. On a tie the priority
  // pointer decides.
  // ---------------------------------------------------------------------------
  logic sel_valid;
  logic sel_idx;

  always_comb begin
    sel_valid = |req_vec;
    sel_idx   = (&req_vec) ? pri_reg : req_vec[1];
  end

  // Read data is sampled on the last WAIT cycle. This is the cycle in which
  // the memory presents the word.
  logic capture_en;
  assign capture_en = (state_reg == ST_WAIT) && (cnt_reg == 3'd1);

  // ---------------------------------------------------------------------------
  // Sequencer. The memory pins and the pulses are registered. Each is loaded
  // on the edge that enters the state in which it must be visible. This keeps
  // the enables and GNT aligned with the ACCESS cycle, and keeps DONE aligned
  // with the RESP cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      pri_reg      <= 1'b0;
      op_idx_reg   <= 1'b0;
      op_we_reg    <= 1'b0;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      mem_d_in_reg <= '0;
      mem_addr_reg <= '0;
      mem_r_en_reg <= 1'b0;
      mem_w_en_reg <= 1'b0;
    end else begin
      // Pulses and memory pins default low. They are driven only for the
      // single cycle in which they apply.
      gnt_reg      <= '0;
      done_reg     <= '0;
      mem_d_in_reg <= '0;
      mem_addr_reg <= '0;
      mem_r_en_reg <= 1'b0;
      mem_w_en_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (sel_valid) begin
            op_idx_reg        <= sel_idx;
            op_we_reg         <= we_vec[sel_idx];
            gnt_reg[sel_idx]  <= 1'b1;
            mem_addr_reg      <= addr_vec[sel_idx];
            if (we_vec[sel_idx]) begin
              mem_w_en_reg <= 1'b1;
              mem_d_in_reg <= din_vec[sel_idx];
            end else begin
              mem_r_en_reg <= 1'b1;
            end
            state_reg <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (op_we_reg) begin
            done_reg[op_idx_reg] <= 1'b1;
            state_reg            <= ST_RESP;
          end else begin
            cnt_reg   <= READ_LAT_CNT;
            state_reg <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt_reg == 3'd1) begin
            done_reg[op_idx_reg] <= 1'b1;
            state_reg            <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end

        ST_RESP: begin
          // Hand the tie-break to the requester that was not just served.
          pri_reg   <= ~op_idx_reg;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester read-data holding registers. Each register changes only
  // when its own read completes. The other requester's traffic never touches
  // it.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] dout_reg;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          dout_reg <= '0;
        end else if (capture_en && (op_idx_reg == 1'(gi))) begin
          dout_reg <= MEM_D_OUT;
        end
      end

      assign dout_vec[gi] = dout_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign A_GNT        = gnt_reg[0];
  assign B_GNT        = gnt_reg[1];
  assign A_DONE       = done_reg[0];
  assign B_DONE       = done_reg[1];
  assign A_DOUT       = dout_vec[0];
  assign B_DOUT       = dout_vec[1];
  assign MEM_D_IN     = mem_d_in_reg;
  assign MEM_ADDR     = mem_addr_reg;
  assign MEM_R_ENABLE = mem_r_en_reg;
  assign MEM_W_ENABLE = mem_w_en_reg;

endmodule
